cpu_debug_mem_sequencer: RTL and testbench

CPU_DEBUG_MEM_SEQUENCER -- requirements
Module: cpu_debug_mem_sequencer

---
 rtl/cpu_debug_mem_sequencer.sv | 119 +++++++++++
 tb/tb_cpu_debug_mem_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/cpu_debug_mem_sequencer.sv
// Debug-port memory sequencer: turns OCI debug strobes into single-word
// read/write requests on a waitrequest-style bus, with a stall timeout and sticky error.
module cpu_debug_mem_sequencer #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [37:0]       jdo,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, ABORT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       mon_q, mon_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic              error_q, error_d;
  logic [7:0]        wcnt_q, wcnt_d;
  logic              any_strobe;

  assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      mon_q   <= '0;
      wdata_q <= '0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mon_q   <= mon_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      error_q <= error_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    mon_d   = mon_q;
    wdata_d = wdata_q;
    ready_d = ready_q;
    error_d = error_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      IDLE: begin
        // Accepting a strobe clears the status, but a lower-priority strobe
        // lost in the same cycle re-flags the error immediately.
        if (take_action_ocimem_a) begin
          addr_d  = jdo[17 +: ADDR_W];
          ready_d = ~jdo[35];
          error_d = take_action_ocimem_b | take_no_action_ocimem_a;
          wcnt_d  = '0;
          if (jdo[35]) state_d = READ;
        end else if (take_action_ocimem_b) begin
          wdata_d = jdo[34:3];
          ready_d = 1'b0;
          error_d = take_no_action_ocimem_a;
          wcnt_d  = '0;
          state_d = WRITE;
        end else if (take_no_action_ocimem_a) begin
          ready_d = 1'b0;
          error_d = 1'b0;
          wcnt_d  = '0;
          state_d = READ;
        end
      end
      READ, WRITE: begin
        if (any_strobe) error_d = 1'b1;
        if (!mem_waitrequest) begin
          if (state_q == READ) mon_d = mem_readdata;
          addr_d  = addr_q + ADDR_W'(1);
          ready_d = 1'b1;
          state_d = IDLE;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
          if (wcnt_d == 8'(TIMEOUT)) state_d = ABORT;
        end
      end
      ABORT: begin
        ready_d = 1'b1;
        error_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_address   = addr_q;
  assign mem_read      = (state_q == READ);
  assign mem_write     = (state_q == WRITE);
  assign mem_writedata = wdata_q;
  assign MonDReg       = mon_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_cpu_debug_mem_sequencer.sv
// Directed vector bench for cpu_debug_mem_sequencer, built with TIMEOUT=4.
module tb_cpu_debug_mem_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        sa, sb, sn;
  logic [37:0] jdo;
  logic [7:0]  mem_address;
  logic        mem_read, mem_write;
  logic [31:0] mem_writedata, mem_readdata, MonDReg;
  logic        mem_waitrequest;
  logic        monitor_ready, monitor_error, busy;

  always #5 clk = ~clk;

  cpu_debug_mem_sequencer #(.ADDR_W(8), .TIMEOUT(4)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .take_action_ocimem_a    (sa),
    .take_action_ocimem_b    (sb),
    .take_no_action_ocimem_a (sn),
    .jdo                     (jdo),
    .mem_address             (mem_address),
    .mem_read                (mem_read),
    .mem_write               (mem_write),
    .mem_writedata           (mem_writedata),
    .mem_readdata            (mem_readdata),
    .mem_waitrequest         (mem_waitrequest),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .busy                    (busy)
  );

  typedef struct {
    logic        rst, a, b, n;
    logic [37:0] jdo;
    logic        wait_r;
    logic [31:0] rdata;
    logic        e_rd, e_wr;
    logic [7:0]  e_addr;
    logic [31:0] e_wdata, e_mon;
    logic        e_rdy, e_err, e_busy;
  } vec_t;

  vec_t vecs[$];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  function automatic logic [37:0] ja(input logic rd, input logic [7:0] a);
    logic [37:0] j;
    j = '0;
    j[35] = rd;
    j[24:17] = a;
    return j;
  endfunction

  function automatic logic [37:0] jb(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  task automatic add(input logic rst, a, b, n, input logic [37:0] j, input logic w,
                     input logic [31:0] rd_data, input logic erd, ewr, input logic [7:0] eaddr,
                     input logic [31:0] ewd, emon, input logic erdy, eerr, ebusy);
    vec_t v;
    v = '{rst, a, b, n, j, w, rd_data, erd, ewr, eaddr, ewd, emon, erdy, eerr, ebusy};
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic idle_inputs();
    reset = 1'b0; sa = 1'b0; sb = 1'b0; sn = 1'b0; jdo = '0;
  endtask

  initial begin
    int unsigned hi_cnt;
    int unsigned cyc;
    idle_inputs();
    mem_waitrequest = 1'b0;
    mem_readdata = '0;

    //  rst a b n  jdo                   wt rdata         rd wr addr   wdata         mon           rdy err busy
    add(1, 0,0,0, '0,                   0, 32'h0,        0, 0, 8'h00, 32'h0,        32'h0,        0, 0, 0);
    add(0, 1,0,0, ja(1, 8'h10),         0, 32'hCAFEF00D, 1, 0, 8'h10, 32'h0,        32'h0,        0, 0, 1);
    add(0, 0,0,0, '0,                   0, 32'hCAFEF00D, 0, 0, 8'h11, 32'h0,        32'hCAFEF00D, 1, 0, 0);
    add(0, 0,1,0, jb(32'h12345678),     0, 32'h0,        0, 1, 8'h11, 32'h12345678, 32'hCAFEF00D, 0, 0, 1);
    add(0, 0,0,0, '0,                   1, 32'h0,        0, 1, 8'h11, 32'h12345678, 32'hCAFEF00D, 0, 0, 1);
    add(0, 0,0,0, '0,                   1, 32'h0,        0, 1, 8'h11, 32'h12345678, 32'hCAFEF00D, 0, 0, 1);
    add(0, 0,0,0, '0,                   1, 32'h0,        0, 1, 8'h11, 32'h12345678, 32'hCAFEF00D, 0, 0, 1);
    add(0, 0,0,0, '0,                   0, 32'h0,        0, 0, 8'h12, 32'h12345678, 32'hCAFEF00D, 1, 0, 0);
    add(0, 1,0,0, ja(0, 8'hFF),         0, 32'h0,        0, 0, 8'hFF, 32'h12345678, 32'hCAFEF00D, 1, 0, 0);
    add(0, 0,0,1, '0,                   0, 32'h0,        1, 0, 8'hFF, 32'h12345678, 32'hCAFEF00D, 0, 0, 1);
    add(0, 0,0,0, '0,                   0, 32'hA5A55A5A, 0, 0, 8'h00, 32'h12345678, 32'hA5A55A5A, 1, 0, 0);
    add(0, 0,0,1, '0,                   0, 32'h0,        1, 0, 8'h00, 32'h12345678, 32'hA5A55A5A, 0, 0, 1);
    add(0, 0,1,0, jb(32'hDEADBEEF),     0, 32'h11112222, 0, 0, 8'h01, 32'h12345678, 32'h11112222, 1, 1, 0);
    add(0, 1,1,0, ja(0, 8'h40),         0, 32'h0,        0, 0, 8'h40, 32'h12345678, 32'h11112222, 1, 1, 0);
    add(0, 0,0,1, '0,                   0, 32'h0,        1, 0, 8'h40, 32'h12345678, 32'h11112222, 0, 0, 1);
    add(0, 0,0,0, '0,                   1, 32'h99999999, 1, 0, 8'h40, 32'h12345678, 32'h11112222, 0, 0, 1);
    add(0, 0,0,0, '0,                   1, 32'h99999999, 1, 0, 8'h40, 32'h12345678, 32'h11112222, 0, 0, 1);
    add(0, 0,0,0, '0,                   1, 32'h99999999, 1, 0, 8'h40, 32'h12345678, 32'h11112222, 0, 0, 1);
    add(0, 0,0,0, '0,                   1, 32'h99999999, 0, 0, 8'h40, 32'h12345678, 32'h11112222, 0, 0, 1);
    add(0, 0,0,0, '0,                   1, 32'h99999999, 0, 0, 8'h40, 32'h12345678, 32'h11112222, 1, 1, 0);
    add(0, 0,0,1, '0,                   1, 32'h0,        1, 0, 8'h40, 32'h12345678, 32'h11112222, 0, 0, 1);
    add(1, 0,0,0, '0,                   1, 32'h0,        0, 0, 8'h00, 32'h0,        32'h0,        0, 0, 0);
    add(0, 0,0,0, '0,                   0, 32'h0,        0, 0, 8'h00, 32'h0,        32'h0,        0, 0, 0);
    add(1, 1,0,0, ja(1, 8'h33),         0, 32'h0,        0, 0, 8'h00, 32'h0,        32'h0,        0, 0, 0);
    add(0, 0,0,0, '0,                   0, 32'h0,        0, 0, 8'h00, 32'h0,        32'h0,        0, 0, 0);

    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; sa = vecs[i].a; sb = vecs[i].b; sn = vecs[i].n;
      jdo = vecs[i].jdo; mem_waitrequest = vecs[i].wait_r; mem_readdata = vecs[i].rdata;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d", i),
          128'({mem_read, mem_write, mem_address, mem_writedata, MonDReg,
                monitor_ready, monitor_error, busy}),
          128'({vecs[i].e_rd, vecs[i].e_wr, vecs[i].e_addr, vecs[i].e_wdata, vecs[i].e_mon,
                vecs[i].e_rdy, vecs[i].e_err, vecs[i].e_busy}));
    end

    // Write held off until timeout: exactly four request cycles, data held, then abort.
    idle_inputs();
    sb = 1'b1; jdo = jb(32'h0BADF00D); mem_waitrequest = 1'b1;
    @(posedge clk);
    #1;
    idle_inputs();
    hi_cnt = 0;
    cyc = 0;
    while (busy && cyc < 20) begin
      if (mem_write) begin
        hi_cnt++;
        chk("wdata_held", 128'(mem_writedata), 128'(32'h0BADF00D));
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("abort_reached_idle", 128'(busy), 128'(1'b0));
    chk("write_req_cycles", 128'(hi_cnt), 128'(4));
    chk("abort_status", 128'({monitor_ready, monitor_error, mem_write}), 128'(3'b110));
    chk("abort_addr_mon", 128'({mem_address, MonDReg}), 128'({8'h00, 32'h0}));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
